// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  // funct3[2] splits the multiply group from the divide group.
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor from the remainder and keep the difference when it does not borrow.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] partial;
  logic [XLEN:0] diff;

  // The shifted remainder needs one extra bit; it is always below 2*divisor,
  // so a restored remainder still fits in XLEN bits.
  assign partial = {rem_i, quo_i[XLEN-1]};
  assign diff    = partial - {1'b0, divisor_i};

  always_comb begin
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = partial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake and flush.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] work_q;
  logic [2*XLEN-1:0] work_d;
  logic [XLEN-1:0]   divisor_q;
  logic              neg_q;
  logic              neg_r_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [2*XLEN-1:0] fast_prod;

  assign a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  assign b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = md_is_div(op) && (b == '0);
  assign div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == MinNeg) && (b == '1);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
  assign fast_prod = '0;
`endif

  // Iteration datapath: multiply keeps {acc_hi, multiplier} and shifts right,
  // divide keeps {remainder, quotient} and shifts left through the step module.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem, div_quo;

  assign mul_sum = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, divisor_q} : '0);

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (work_q[2*XLEN-1:XLEN]),
    .quo_i     (work_q[XLEN-1:0]),
    .divisor_i (divisor_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  assign work_d = md_is_div(op_q) ? {div_rem, div_quo} : {mul_sum, work_q[XLEN-1:1]};

  // Sign correction and field selection applied in FIX.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  assign prod_fix = neg_q   ? -work_q : work_q;
  assign quo_fix  = neg_q   ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
  assign rem_fix  = neg_r_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    case (op_q)
      MD_MUL:                      fix_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             fix_val = quo_fix;
      default:                     fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            op_q    <= op;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            neg_q   <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            if (div_zero) begin
              // Final values preloaded; FIX must not re-sign them.
              work_q  <= {a, {XLEN{1'b1}}};
              neg_q   <= 1'b0;
              neg_r_q <= 1'b0;
              state_q <= S_FIX;
            end else if (div_ovf) begin
              work_q  <= {{XLEN{1'b0}}, MinNeg};
              neg_q   <= 1'b0;
              neg_r_q <= 1'b0;
              state_q <= S_FIX;
            end else if (FastMul && !md_is_div(op)) begin
              work_q  <= fast_prod;
              state_q <= S_FIX;
            end else if (md_is_div(op)) begin
              work_q    <= {{XLEN{1'b0}}, a_mag};
              divisor_q <= b_mag;
              state_q   <= S_CALC;
            end else begin
              work_q    <= {{XLEN{1'b0}}, b_mag};
              divisor_q <= a_mag;
              state_q   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_val;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected result and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LM = 2;
`else
  localparam int LM = 34;
`endif
  localparam int LD = 34;
  localparam int LS = 2;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          when;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    if (!rst && done) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, no transaction pending", result, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (result !== e.val || cyc != e.when) begin
          bad++;
          $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d", e.name, result, cyc, e.val, e.when);
        end else begin
          $display("ok   %s: result=%h at cycle %0d", e.name, result, cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Issue one op, scramble inputs while busy, wait (bounded) for done and
  // check busy stayed high every cycle before it and dropped with done.
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat, input string nm);
    int  n;
    bit  busy_ok;
    bit  seen;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    n = cyc;
    sb_q.push_back('{exp, n + lat, nm});
    busy_ok = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no done within 60 cycles", nm);
      void'(sb_q.pop_back());
    end else begin
      chk({nm, "_busy"}, {30'd0, busy_ok, busy}, 32'd2);
    end
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    run(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LM, "mul_7_m3");
    run(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LM, "mulhu_max");
    run(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LM, "mulh_m1_m1");
    run(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LM, "mulhsu_m1_2");
    run(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LM, "mulh_min_min");
    run(MD_MULHU,  32'h80000000, 32'd2,        32'h00000001, LM, "mulhu_carry");
    run(MD_MUL,    32'd3,        32'd5,        32'd15,       LM, "mul_3_5");
    run(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LD, "div_m7_2");
    run(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LD, "rem_m7_2");
    run(MD_DIVU,   32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, LD, "divu_big");
    run(MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LD, "div_7_m2");
    run(MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        LD, "rem_7_m2");
    run(MD_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, LD, "rem_m7_m2");
    run(MD_DIVU,   32'd100,      32'd7,        32'd14,       LD, "divu_100_7");
    run(MD_REMU,   32'd100,      32'd7,        32'd2,        LD, "remu_100_7");
    run(MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, LS, "div_by0");
    run(MD_REM,    32'd5,        32'd0,        32'd5,        LS, "rem_by0");
    run(MD_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, LS, "divu_by0");
    run(MD_REMU,   32'd9,        32'd0,        32'd9,        LS, "remu_by0");
    run(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        LS, "rem_ovf");
    run(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LS, "div_ovf");

    // Flush at CALC iteration 10: no done, busy drops, result keeps 80000000.
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    chk("flush_result_kept", result, 32'h80000000);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("flush_no_done", 32'(dones), 32'd0);

    // Flush together with start in IDLE: start must not be taken.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MD_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    run(MD_DIVU,   32'd50,       32'd5,        32'd10,       LD, "divu_after_flush");

    // Asynchronous reset between edges while in CALC.
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(MD_MUL,    32'd3,        32'd5,        32'd15,       LM, "mul_after_rst");
    run(MD_REMU,   32'd1000,     32'd3,        32'd1,        LD, "remu_after_rst");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit alongside the single-cycle ALU in the EX stage. It is the multi-cycle end of the EX-stage operation interface.
- Accepts an operation from the ID/EX register with a start/busy/done handshake and returns a 32-bit result to EX/MEM.
- The hazard unit stalls IF/ID/EX while busy is high.
- flush cancels an in-flight operation on a branch mispredict.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  32  rs1 operand (forwarded value).
- b  in  32  rs2 operand (forwarded value).
- flush  in  1  abort current operation.
- busy  out  1  operation in progress; request not accepted.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  32  result; holds value until next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch op and operand magnitudes, plus result-sign and remainder-sign flags.
  - Signed views: MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU/DIVU/REMU/MUL treat both as unsigned magnitudes.
  - counter=0, busy=1 on the next cycle, then go to CALC.
  - Special cases skip CALC and go to FIX with the final value preloaded:
    - Divide by zero: DIV/DIVU quotient=32'hFFFFFFFF; REM/REMU remainder=a.
    - Signed overflow (a=32'h80000000, b=32'hFFFFFFFF, DIV/REM): quotient=32'h80000000, remainder=0.
- CALC: one iteration per cycle, XLEN iterations; when counter==XLEN-1, go to FIX.
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract; 64-bit {remainder,quotient} register, one quotient bit per cycle.
- FIX:
  - Apply two's-complement sign correction.
  - MUL selects product[31:0]; MULH* selects product[63:32]; DIV* selects quotient; REM* selects remainder.
  - Remainder sign follows dividend; quotient sign is the XOR of the operand signs.
  - Write result, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
  - A start in the DONE cycle is ignored; the pipeline reissues it after the stall releases.
- Latency, start sampled at cycle N:
  - Normal: done at cycle N+XLEN+2 (N+34).
  - Special case: done at N+2.
- busy is high from N+1 through the cycle before done.
- flush:
  - In CALC or FIX: go to IDLE next cycle; busy=0, no done, result unchanged.
  - In IDLE: ignored.
  - Simultaneous with start in IDLE: start is not accepted.
- Operands and op are not sampled after acceptance; changes on a/b/op while busy have no effect.
- All arithmetic is modulo 2^64 internally, with no saturation.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: all multiply ops take the single-cycle path. IDLE goes to FIX, the full 64-bit signed/unsigned product is computed combinationally (inferred DSP), and done arrives at N+2. Divide is unchanged.
- Undefined: multiply uses the iterative CALC path (N+34). No ports differ.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants MD_MUL..MD_REMU.
  - state encoding constants S_IDLE, S_CALC, S_FIX, S_DONE.
  - XLEN default.
- Op constants also go into ctrl_encode_def alongside the ALUOp codes so the decoder can drive op.
- One natural sub-module: muldiv_div_step, the combinational one-iteration restoring-divide step (remainder, quotient in; next remainder, quotient out). The top level holds the FSM, counter, sign logic and the multiply path.

Test Plan:
- MUL a=7, b=-3 (32'hFFFFFFFD) -> result=32'hFFFFFFEB, done exactly 34 cycles after start, busy high cycles 1..33.
- MULHU a=b=32'hFFFFFFFF -> 32'hFFFFFFFE; MULH same operands -> 32'h00000000; MULHSU a=-1, b=2 -> 32'hFFFFFFFF.
- DIV a=-7, b=2 -> 32'hFFFFFFFD; REM same -> 32'hFFFFFFFF; DIVU a=32'hFFFFFFFE, b=2 -> 32'h7FFFFFFF.
- DIV b=0 a=5 -> 32'hFFFFFFFF; REM b=0 a=5 -> 5; DIV a=32'h80000000, b=-1 -> 32'h80000000, done at N+2.
- flush asserted at CALC iteration 10 -> no done pulse, busy=0 next cycle, result keeps prior value; a new start then completes normally.
- rst asserted mid-CALC, asynchronously between edges -> busy/done/result=0 immediately; with MULDIV_FAST_MUL_EN defined, MUL 3×5 -> 15 at N+2.
